// File: rtl/mem_bus_pkg.sv
// Shared constants for the MemoryUnit bus arbiter: bus widths, master ids,
// FSM state encoding and a small one-hot helper.
package mem_bus_pkg;

    localparam int ADDR_W_DEF = 27;
    localparam int DATA_W_DEF = 32;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DMA = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_ISSUE     = 3'd1;
    localparam state_t S_WAIT_BUSY = 3'd2;
    localparam state_t S_WAIT_DONE = 3'd3;
    localparam state_t S_COMPLETE  = 3'd4;

    function automatic logic [1:0] onehot2(input logic idx);
        return (idx == M_DMA) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_select2.sv
// Two-way round-robin pick: masked requesters are ignored, and on a tie the
// master that was not served last wins.
module rr_select2
    import mem_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    logic [1:0] elig;

    always_comb begin
        elig   = req & ~mask;
        valid  = |elig;
        winner = M_CPU;
        case (elig)
            2'b01:   winner = M_CPU;
            2'b10:   winner = M_DMA;
            2'b11:   winner = ~last;
            default: winner = M_CPU;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the MemoryUnit CPU bus between the CPU (m0) and the DMA engine (m1),
// sequencing each grant through the start/busy handshake and returning q.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [DATA_W-1:0] m0_data,
    input  logic              m0_we,
    input  logic              m0_start,
    output logic              m0_busy,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_q,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m1_data,
    input  logic              m1_we,
    input  logic              m1_start,
    output logic              m1_busy,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_q,
    output logic [ADDR_W-1:0] mu_address,
    output logic [DATA_W-1:0] mu_data,
    output logic              mu_we,
    output logic              mu_start,
    input  logic              mu_busy,
    input  logic [DATA_W-1:0] mu_q,
    input  logic              mu_init_done,
    output logic              grant
);

    state_t     state;
    logic       last;
    logic       first_idle;
    logic [1:0] sel_mask;
    logic       sel_valid;
    logic       sel_winner;
    logic       active;

    // The just-served master sits out one IDLE cycle so it can drop start
    // after done without being granted a phantom repeat.
    assign sel_mask = first_idle ? onehot2(last) : 2'b00;

    rr_select2 u_sel (
        .req    ({m1_start, m0_start}),
        .mask   (sel_mask),
        .last   (last),
        .valid  (sel_valid),
        .winner (sel_winner)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state      <= S_IDLE;
            last       <= M_DMA;
            grant      <= M_CPU;
            first_idle <= 1'b0;
            mu_address <= '0;
            mu_data    <= '0;
            mu_we      <= 1'b0;
            m0_q       <= '0;
            m1_q       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    first_idle <= 1'b0;
                    if (mu_init_done && sel_valid) begin
                        grant      <= sel_winner;
                        mu_address <= (sel_winner == M_DMA) ? m1_address : m0_address;
                        mu_data    <= (sel_winner == M_DMA) ? m1_data    : m0_data;
                        mu_we      <= (sel_winner == M_DMA) ? m1_we      : m0_we;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_WAIT_BUSY;
                S_WAIT_BUSY: begin
                    if (mu_busy) state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    // q is captured on writes too; the owner simply ignores it.
                    if (!mu_busy) begin
                        if (grant == M_DMA) m1_q <= mu_q;
                        else                m0_q <= mu_q;
                        state <= S_COMPLETE;
                    end
                end
                S_COMPLETE: begin
                    last       <= grant;
                    first_idle <= 1'b1;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign active   = (state == S_ISSUE) || (state == S_WAIT_BUSY) || (state == S_WAIT_DONE);
    assign mu_start = (state == S_ISSUE);
    assign m0_busy  = active && (grant == M_CPU);
    assign m1_busy  = active && (grant == M_DMA);
    assign m0_done  = (state == S_COMPLETE) && (grant == M_CPU);
    assign m1_done  = (state == S_COMPLETE) && (grant == M_DMA);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a MemoryUnit model and a queue of
// expected transactions checked at each mu_start and done pulse.
module tb_mem_bus_arbiter;

    localparam int AW = 27;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          nreset;
    logic [AW-1:0] m0_address, m1_address, mu_address;
    logic [DW-1:0] m0_data, m1_data, mu_data, m0_q, m1_q, mu_q;
    logic          m0_we, m1_we, m0_start, m1_start;
    logic          m0_busy, m1_busy, m0_done, m1_done;
    logic          mu_we, mu_start, mu_busy, mu_init_done, grant;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .nreset(nreset),
        .m0_address(m0_address), .m0_data(m0_data), .m0_we(m0_we), .m0_start(m0_start),
        .m0_busy(m0_busy), .m0_done(m0_done), .m0_q(m0_q),
        .m1_address(m1_address), .m1_data(m1_data), .m1_we(m1_we), .m1_start(m1_start),
        .m1_busy(m1_busy), .m1_done(m1_done), .m1_q(m1_q),
        .mu_address(mu_address), .mu_data(mu_data), .mu_we(mu_we), .mu_start(mu_start),
        .mu_busy(mu_busy), .mu_q(mu_q), .mu_init_done(mu_init_done), .grant(grant)
    );

    typedef struct {
        bit            m;
        logic [AW-1:0] a;
        bit            we;
        logic [DW-1:0] d;
        logic [DW-1:0] q;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_starts = 0;
    bit   inflight = 1'b0;
    int   bdelay = 4;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return 32'hC0DE_0000 ^ {5'b0, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input bit m, input logic [AW-1:0] a, input bit we,
                        input logic [DW-1:0] d, input logic [DW-1:0] q);
        exp_t x;
        x.m = m; x.a = a; x.we = we; x.d = d; x.q = q;
        exp_q.push_back(x);
    endtask

    task automatic wait_done(input bit m, output int k);
        k = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if ((m ? m1_done : m0_done) === 1'b1) begin
                k = i;
                break;
            end
        end
    endtask

    // MemoryUnit model: busy for bdelay cycles starting the cycle after start.
    logic [AW-1:0] cap_a;
    logic          cap_we;
    logic [DW-1:0] cap_d;
    int            bcnt;
    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            mu_busy <= 1'b0;
            mu_q    <= '0;
            bcnt    <= 0;
        end else if (mu_start) begin
            mu_busy <= 1'b1;
            bcnt    <= bdelay;
            cap_a   <= mu_address;
            cap_we  <= mu_we;
            cap_d   <= mu_data;
        end else if (bcnt > 1) begin
            bcnt <= bcnt - 1;
        end else if (bcnt == 1) begin
            bcnt    <= 0;
            mu_busy <= 1'b0;
            if (cap_we)                mu_q <= cap_d;
            else if (cap_a == 27'h123) mu_q <= 32'hDEAD_BEEF;
            else                       mu_q <= pat(cap_a);
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (nreset) begin
            if (mu_start === 1'b1) begin
                chk("start_expected", exp_q.size() > 0, 1);
                chk("no_overlap", inflight, 0);
                chk("busy_exclusive", m0_busy & m1_busy, 0);
                if (exp_q.size() > 0) begin
                    chk("issue_grant", grant, exp_q[0].m);
                    chk("issue_addr", mu_address, exp_q[0].a);
                    chk("issue_we", mu_we, exp_q[0].we);
                    if (exp_q[0].we) chk("issue_data", mu_data, exp_q[0].d);
                end
                inflight = 1'b1;
                n_starts++;
            end
            if ((m0_done | m1_done) === 1'b1) begin
                chk("done_exclusive", m0_done & m1_done, 0);
                chk("done_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("done_owner", m1_done, e.m);
                    chk("done_q", e.m ? m1_q : m0_q, e.q);
                end
                inflight = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        int  s0;
        bit  seen;
        nreset = 1'b0; mu_init_done = 1'b0;
        m0_address = '0; m0_data = '0; m0_we = 1'b0; m0_start = 1'b0;
        m1_address = '0; m1_data = '0; m1_we = 1'b0; m1_start = 1'b0;
        #12;
        chk("rst_mu_start", mu_start, 0);
        chk("rst_mu_we", mu_we, 0);
        chk("rst_mu_address", mu_address, 0);
        chk("rst_mu_data", mu_data, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", {m0_busy, m1_busy}, 0);
        chk("rst_done", {m0_done, m1_done}, 0);
        chk("rst_q", {m0_q, m1_q}, 0);
        @(posedge clk); #1 nreset = 1'b1;

        // Init gating: request pending but no grant until init_done.
        m0_address = 27'h50; m0_start = 1'b1;
        push(0, 27'h50, 0, '0, pat(27'h50));
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mu_start === 1'b1 || m0_busy === 1'b1) seen = 1'b1;
        end
        chk("init_gate_no_start", seen, 0);
        @(posedge clk); #1 mu_init_done = 1'b1;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (mu_start === 1'b1) begin k = i; break; end
        end
        chk("init_start_delay", k, 2);
        wait_done(0, k);
        chk("init_txn_done", k > 0, 1);
        @(posedge clk); #1 m0_start = 1'b0;
        repeat (3) @(posedge clk);

        // Single read m0, B=4: done in the 8th cycle counting the request cycle.
        #1 m0_address = 27'h123; m0_start = 1'b1;
        push(0, 27'h123, 0, '0, 32'hDEAD_BEEF);
        s0 = n_starts; seen = 1'b0;
        k = 0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (m1_busy === 1'b1 || m1_done === 1'b1) seen = 1'b1;
            if (m0_done === 1'b1) begin k = i; break; end
        end
        chk("read_latency", k, 8);
        chk("read_q", m0_q, 32'hDEAD_BEEF);
        chk("read_m1_idle", seen, 0);
        chk("read_one_start", n_starts - s0, 1);
        @(posedge clk); #1 m0_start = 1'b0;

        // Reset so that m0 wins the first contended grant.
        repeat (2) @(posedge clk);
        #1 nreset = 1'b0;
        #5 nreset = 1'b1;

        // Contention: four transactions alternating m0, m1, m0, m1.
        @(posedge clk); #1;
        m0_address = 27'hA00; m1_address = 27'hB00; m0_start = 1'b1; m1_start = 1'b1;
        push(0, 27'hA00, 0, '0, pat(27'hA00));
        push(1, 27'hB00, 0, '0, pat(27'hB00));
        push(0, 27'hA00, 0, '0, pat(27'hA00));
        push(1, 27'hB00, 0, '0, pat(27'hB00));
        s0 = n_starts; k = 0;
        for (int i = 0; i < 400 && k < 4; i++) begin
            @(negedge clk);
            if ((m0_done | m1_done) === 1'b1) k++;
        end
        chk("contend_done_count", k, 4);
        @(posedge clk); #1 m0_start = 1'b0; m1_start = 1'b0;
        repeat (6) @(posedge clk);
        chk("contend_starts", n_starts - s0, 4);
        chk("contend_queue_empty", exp_q.size(), 0);

        // Back-to-back m1: one transaction per start assertion.
        #1 m1_address = 27'h2222; m1_start = 1'b1;
        push(1, 27'h2222, 0, '0, pat(27'h2222));
        s0 = n_starts;
        wait_done(1, k);
        chk("b2b_first_done", k > 0, 1);
        @(posedge clk); #1 m1_start = 1'b0;
        repeat (2) @(posedge clk);
        #1 m1_address = 27'h3333; m1_start = 1'b1;
        push(1, 27'h3333, 0, '0, pat(27'h3333));
        wait_done(1, k);
        chk("b2b_second_done", k > 0, 1);
        @(posedge clk); #1 m1_start = 1'b0;
        repeat (8) @(posedge clk);
        chk("b2b_starts", n_starts - s0, 2);

        // Write from m1.
        #1 m1_address = 27'h100_0000; m1_data = 32'h55; m1_we = 1'b1; m1_start = 1'b1;
        push(1, 27'h100_0000, 1, 32'h55, 32'h55);
        wait_done(1, k);
        chk("write_done", k > 0, 1);
        @(posedge clk); #1 m1_start = 1'b0; m1_we = 1'b0;
        repeat (3) @(posedge clk);

        // Reset in WAIT_DONE.
        bdelay = 20;
        #1 m0_address = 27'h777; m0_start = 1'b1;
        push(0, 27'h777, 0, '0, pat(27'h777));
        k = 0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (mu_busy === 1'b1) begin k = i; break; end
        end
        chk("rst_mid_busy_seen", k > 0, 1);
        @(negedge clk);
        #2 nreset = 1'b0; m0_start = 1'b0;
        #1;
        chk("midrst_busy", {m0_busy, m1_busy}, 0);
        chk("midrst_done", {m0_done, m1_done}, 0);
        chk("midrst_mu_address", mu_address, 0);
        chk("midrst_mu_data", mu_data, 0);
        chk("midrst_m0_q", m0_q, 0);
        chk("midrst_m1_q", m1_q, 0);
        chk("midrst_grant", grant, 0);
        exp_q.delete();
        inflight = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if ((m0_done | m1_done | mu_start) === 1'b1) seen = 1'b1;
        end
        chk("midrst_quiet", seen, 0);
        @(posedge clk); #1 nreset = 1'b1; bdelay = 2;
        m0_address = 27'h444; m1_address = 27'h555; m0_start = 1'b1; m1_start = 1'b1;
        push(0, 27'h444, 0, '0, pat(27'h444));
        push(1, 27'h555, 0, '0, pat(27'h555));
        wait_done(0, k);
        chk("post_rst_m0_first", k > 0, 1);
        @(posedge clk); #1 m0_start = 1'b0;
        wait_done(1, k);
        chk("post_rst_m1_next", k > 0, 1);
        @(posedge clk); #1 m1_start = 1'b0;
        repeat (6) @(posedge clk);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter in front of the MemoryUnit CPU bus (address/data/we/start/busy/q). It shares the single memory bus between master 0 (CPU) and master 1 (a DMA/blitter engine). Requests are granted fairly, each granted access is sequenced through the MemoryUnit start/busy handshake, and the read data is returned to the owner. It sits in the top level between the CPU/DMA and the MemoryUnit instance. No grants are issued until the MemoryUnit reports `initDone`.

## Interface
Parameters:
- `ADDR_W`, 27: bus address width.
- `DATA_W`, 32: bus data width.

Ports:
- `clk` in 1: system clock.
- `nreset` in 1: asynchronous, active-low reset.
- `m0_address`, `m1_address` in ADDR_W: request address, held stable while `mN_start`=1.
- `m0_data`, `m1_data` in DATA_W: write data, held stable while `mN_start`=1.
- `m0_we`, `m1_we` in 1: write enable, held stable while `mN_start`=1.
- `m0_start`, `m1_start` in 1: level request.
- `m0_busy`, `m1_busy` out 1: request accepted, not yet complete.
- `m0_done`, `m1_done` out 1: 1-cycle completion pulse.
- `m0_q`, `m1_q` out DATA_W: read data, valid while `mN_done`=1 and held until that master's next completion.
- `mu_address` out ADDR_W, `mu_data` out DATA_W, `mu_we` out 1: registered request to MemoryUnit.
- `mu_start` out 1: 1-cycle start pulse.
- `mu_busy` in 1, `mu_q` in DATA_W, `mu_init_done` in 1: MemoryUnit status.
- `grant` out 1: owner of the current/last transaction (0 = m0).

## Operation
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, COMPLETE.
- IDLE: if `mu_init_done`=0, stay. Otherwise select an eligible requester; if none, stay.
  - If both request, the winner is the master not in `last`, which gives round-robin.
  - On selection: latch `grant`, register `mu_address`/`mu_data`/`mu_we` from the winner, set `mN_busy`, go to ISSUE.
- ISSUE: `mu_start`=1 for exactly this cycle; go to WAIT_BUSY.
- WAIT_BUSY: wait for `mu_busy`=1, then go to WAIT_DONE.
- WAIT_DONE: when `mu_busy`=0, latch `mu_q` into `mN_q` of the owner and go to COMPLETE.
- COMPLETE: `mN_done`=1 for the owner, `mN_busy`=0, `last`←`grant`, go to IDLE.
- Eligibility: in the first IDLE cycle after COMPLETE, the just-served master is masked. This lets a requester drop `start` one cycle after `done` without a spurious repeat. If it still requests in the second IDLE cycle, that is a new transaction.
- Writes: `mN_q` is updated with `mu_q` anyway; software ignores it.
- Non-owner outputs: `busy`=0 and `done`=0 at all times; its `q` is unchanged.
- `mu_*` request registers hold their value until the next grant.

## Timing
- Reset (async, immediate): state=IDLE, `last`=1 (so m0 wins first), `grant`=0. All of `mu_start`, `mu_we`, `mN_busy`, `mN_done` are 0. `mu_address`, `mu_data`, `mN_q` are 0.
- Latency, with request seen in cycle t and `mu_busy` high for B≥1 cycles starting at t+2:
  - ISSUE at t+1.
  - `mu_busy` seen at t+2.
  - `mu_busy` low at t+2+B.
  - `done` at t+3+B.
  - Overhead is 3 cycles beyond B.
- If `mu_busy` rises later than t+2, the FSM waits in WAIT_BUSY indefinitely. No timeout.
- Simultaneous requests: exactly one grant per IDLE decision. Under continuous contention, grants alternate m0, m1, m0, and so on.
- `mu_init_done` falling mid-transaction does not abort it; it only blocks new grants.
- `nreset` asserted mid-transaction: immediate return to reset values, with no `done` pulse. The MemoryUnit is reset by the same source.
- A `start` that drops before the grant is simply not served. A `start` that drops after the grant does not abort the transaction.

## Structure
- Shared package `mem_bus_pkg`:
  - state enum.
  - `ADDR_W`/`DATA_W` defaults.
  - master index constants `M_CPU`=0, `M_DMA`=1.
- Sub-module `rr_select2`: combinational 2-way round-robin pick from `req[1:0]`, `mask[1:0]` and `last`, producing `valid` and `winner`.
- The FSM, request registers and return path live in `mem_bus_arbiter`.

## Test plan
- Init gating: `mu_init_done`=0 and `m0_start`=1 for 10 cycles → `mu_start` stays 0. Raise `mu_init_done` → `mu_start` pulses exactly 2 cycles later.
- Single read, m0, address 0x0000123, MemoryUnit model with B=4 returning 0xDEADBEEF → one `mu_start` pulse, `m0_done` 7 cycles after the request, `m0_q`=0xDEADBEEF, `m1_*` idle.
- Contention: both masters hold `start` for 4 transactions → grant order m0, m1, m0, m1. Each `mu_address` matches its owner, and no two transactions overlap.
- Back-to-back same master: m1 drops `start` one cycle after `done`, then re-asserts → exactly one transaction per assertion, and the mask prevents a duplicate.
- Write: m1 writes 0x00000055 to 0x1000000 → `mu_we`=1 and `mu_data`=0x55 at the `mu_start` pulse; `m1_done` pulses.
- Reset mid-transaction: `nreset` low in WAIT_DONE → all outputs at reset values in the same cycle, no `done` pulse. After release, m0 is granted first.
